gcd32_requester: RTL and testbench

- Initiator side of the GCD engine start/done interface.
- Accepts operand pairs on a valid/ready input stream and issues a one-cycle start pulse to an external 32-bit subtractive GCD engine.
- Waits for the engine's done pulse, then presents the result on a valid/ready output stream.
- Handles the cases the engine cannot: zero operands are bypassed, a hung engine is recovered by timeout and engine reset, and stale done pulses are ignored.

---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_timeout_timer.sv | 40 ++++
 rtl/gcd32_requester.sv | 147 ++++++++++++++
 tb/tb_gcd32_requester.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester, the engine and the testbench.
//   GCD_WIDTH        default operand/result width
//   ENG_RESET_CYCLES cycles eng_resetn is held low when recovering a hung engine
//   gcd_state_e      requester FSM states
package gcd_pkg;

    localparam int unsigned GCD_WIDTH        = 32;
    localparam int unsigned ENG_RESET_CYCLES = 2;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StRecover
    } gcd_state_e;

endpackage

// File: rtl/gcd_timeout_timer.sv
// Loadable up-counter used to bound how long the requester waits for the engine.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clear        synchronous clear to zero (highest priority)
//   load         load load_value
//   load_value   value loaded when load is high
//   enable       count up by one
//   terminal     count has reached TIMEOUT_CYCLES-1
module gcd_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [TW-1:0] load_value,
    input  logic          enable,
    output logic          terminal
);

    localparam logic [TW-1:0] TERM_COUNT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign terminal = (count_q == TERM_COUNT);

endmodule

// File: rtl/gcd32_requester.sv
// Initiator side of the GCD engine start/done interface. Takes operand pairs on a
// valid/ready stream, starts the external engine, and returns the result on a
// valid/ready stream. Zero operands bypass the engine, a hung engine is timed out
// and reset, and done pulses outside the wait window are ignored.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     operand stream handshake; in_x, in_y operands
//   out_valid/out_ready   result stream handshake; out_gcd result (0 on error),
//                         out_err timeout flag, out_bypass zero-operand flag
//   eng_start             one-cycle start pulse; eng_x, eng_y engine operands
//   eng_resetn            synchronous active-low engine reset
//   eng_gcd, eng_done     engine result and one-cycle done pulse
//   done_cnt              wrapping count of engine-completed results
module gcd32_requester
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH          = GCD_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_gcd,
    output logic                 out_err,
    output logic                 out_bypass,
    output logic                 eng_start,
    output logic [WIDTH-1:0]     eng_x,
    output logic [WIDTH-1:0]     eng_y,
    output logic                 eng_resetn,
    input  logic [WIDTH-1:0]     eng_gcd,
    input  logic                 eng_done,
    output logic [CNT_WIDTH-1:0] done_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned RW = $clog2(ENG_RESET_CYCLES);

    gcd_state_e    state_q, state_d;
    logic          started_q;  // low only until the first edge after reset
    logic [RW-1:0] rec_cnt_q;
    logic          timer_tc;
    logic          accept, bypass, wait_done, wait_timeout, rec_last;

    assign accept       = in_valid & in_ready;
    assign bypass       = (in_x == '0) || (in_y == '0);
    assign wait_done    = (state_q == StWait) & eng_done;
    // Done wins over a coincident timeout.
    assign wait_timeout = (state_q == StWait) & ~eng_done & timer_tc;
    assign rec_last     = (rec_cnt_q == RW'(ENG_RESET_CYCLES - 1));

    gcd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q == StIssue),
        .load      (1'b0),
        .load_value({TW{1'b0}}),
        .enable    (state_q == StWait),
        .terminal  (timer_tc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = bypass ? StResp : StIssue;
            StIssue:   state_d = StWait;
            StWait: begin
                if (eng_done)      state_d = StResp;
                else if (timer_tc) state_d = StRecover;
            end
            StRecover: if (rec_last) state_d = StResp;
            StResp:    if (out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        eng_start  = 1'b0;
        eng_resetn = started_q;
        unique case (state_q)
            StIdle:    in_ready   = started_q;
            StIssue:   eng_start  = 1'b1;
            StResp:    out_valid  = 1'b1;
            StRecover: eng_resetn = 1'b0;
            default:   ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q  <= 1'b0;
            rec_cnt_q  <= '0;
            out_gcd    <= '0;
            out_err    <= 1'b0;
            out_bypass <= 1'b0;
            eng_x      <= '0;
            eng_y      <= '0;
            done_cnt   <= '0;
        end else begin
            started_q <= 1'b1;
            rec_cnt_q <= (state_q == StRecover) ? rec_cnt_q + 1'b1 : '0;
            if (accept) begin
                if (bypass) begin
                    out_gcd    <= in_x | in_y;
                    out_err    <= 1'b0;
                    out_bypass <= 1'b1;
                end else begin
                    eng_x <= in_x;
                    eng_y <= in_y;
                end
            end
            if (wait_done) begin
                out_gcd    <= eng_gcd;
                out_err    <= 1'b0;
                out_bypass <= 1'b0;
                done_cnt   <= done_cnt + 1'b1;
            end
            if (wait_timeout) begin
                out_gcd    <= '0;
                out_err    <= 1'b1;
                out_bypass <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gcd32_requester.sv
// Scoreboard bench for gcd32_requester with a behavioural engine model.
module tb_gcd32_requester;
    import gcd_pkg::*;

    localparam int unsigned W  = GCD_WIDTH;
    localparam int unsigned TO = 16;
    localparam int unsigned CW = 2;

    typedef struct {
        logic [W-1:0]  g;
        logic          err;
        logic          byp;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [W-1:0]  in_x = '0, in_y = '0;
    logic          out_valid, out_ready = 1'b1;
    logic [W-1:0]  out_gcd;
    logic          out_err, out_bypass;
    logic          eng_start, eng_resetn;
    logic [W-1:0]  eng_x, eng_y, eng_gcd;
    logic          eng_done;
    logic [CW-1:0] done_cnt;

    // Engine model plus stale-pulse injection
    logic          model_done = 1'b0;
    logic [W-1:0]  model_gcd = '0;
    logic          inj_done = 1'b0;
    bit            eng_hang = 1'b0;
    bit            busy = 1'b0;
    int            lat_cnt = 0;
    int            eng_lat = 10;

    assign eng_done = model_done | inj_done;
    assign eng_gcd  = inj_done ? W'(99) : model_gcd;

    exp_t          sb[$];
    logic [CW-1:0] exp_cnt = '0;
    int            n_cmp = 0, n_err = 0;
    int            n_start = 0, n_ov = 0;
    logic [W-1:0]  last_sx = '0, last_sy = '0;

    gcd32_requester #(
        .WIDTH         (W),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gcd   (out_gcd),
        .out_err   (out_err),
        .out_bypass(out_bypass),
        .eng_start (eng_start),
        .eng_x     (eng_x),
        .eng_y     (eng_y),
        .eng_resetn(eng_resetn),
        .eng_gcd   (eng_gcd),
        .eng_done  (eng_done),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != '0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (!eng_resetn) begin
            busy <= 1'b0;
        end else if (eng_start) begin
            busy      <= 1'b1;
            lat_cnt   <= eng_lat - 1;
            model_gcd <= gcd_f(eng_x, eng_y);
        end else if (busy && !eng_hang) begin
            if (lat_cnt == 0) begin
                model_done <= 1'b1;
                busy       <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // Monitor: pops one expectation per output handshake
    always @(negedge clk) begin
        if (eng_start) begin
            n_start <= n_start + 1;
            last_sx <= eng_x;
            last_sy <= eng_y;
        end
        if (out_valid) n_ov <= n_ov + 1;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected result", 64'(out_gcd), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_gcd", 64'(out_gcd), 64'(e.g));
                check("out_err", 64'(out_err), 64'(e.err));
                check("out_bypass", 64'(out_bypass), 64'(e.byp));
                check("done_cnt", 64'(done_cnt), 64'(e.cnt));
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] g,
                        input logic err, input logic byp);
        exp_t e;
        int   i;
        if (!err && !byp) exp_cnt++;
        e.g = g; e.err = err; e.byp = byp; e.cnt = exp_cnt;
        sb.push_back(e);
        in_x = x; in_y = y; in_valid = 1'b1;
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Junk on the operands while not ready must not matter
        in_x = $urandom; in_y = $urandom;
        check("accept", 64'(i < 50), 64'd1);
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !out_valid) break;
        end
        check("drain", 64'(i < 200), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, ov0, k, lows;
        logic prev;

        // Reset state
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", 64'(in_ready), 0);
        check("rst out_valid", 64'(out_valid), 0);
        check("rst eng_start", 64'(eng_start), 0);
        check("rst eng_resetn", 64'(eng_resetn), 0);
        check("rst out_gcd", 64'(out_gcd), 0);
        check("rst done_cnt", 64'(done_cnt), 0);
        reset = 1'b0;
        #1 check("eng_resetn held after release", 64'(eng_resetn), 0);
        @(posedge clk); #1;
        check("eng_resetn rises", 64'(eng_resetn), 1);
        check("in_ready rises", 64'(in_ready), 1);

        // Engine path
        s0 = n_start; ov0 = n_ov;
        send(48, 18, 6, 1'b0, 1'b0);
        check("engine no early valid", 64'(out_valid), 0);
        wait_drain();
        check("start pulses", 64'(n_start - s0), 1);
        check("eng_x", 64'(last_sx), 48);
        check("eng_y", 64'(last_sy), 18);
        check("out_valid cycles", 64'(n_ov - ov0), 1);

        // Bypass: result valid one cycle after accept, engine untouched
        s0 = n_start;
        send(0, 7, 7, 1'b0, 1'b1);
        check("bypass valid T+1 a", 64'(out_valid), 1);
        wait_drain();
        send(9, 0, 9, 1'b0, 1'b1);
        check("bypass valid T+1 b", 64'(out_valid), 1);
        wait_drain();
        send(0, 0, 0, 1'b0, 1'b1);
        check("bypass valid T+1 c", 64'(out_valid), 1);
        wait_drain();
        check("bypass no start", 64'(n_start - s0), 0);

        // Timeout: 1 ISSUE + 16 WAIT + 2 RECOVER before RESP
        eng_hang = 1'b1;
        send(5, 3, 0, 1'b1, 1'b0);
        k = 0; lows = 0; prev = 1'b1;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (!eng_resetn) lows++;
            if (!out_valid) prev = eng_resetn;
        end
        check("timeout latency", 64'(k), 19);
        check("recover low cycles", 64'(lows), 2);
        check("resetn low before valid", 64'(prev), 0);
        wait_drain();
        eng_hang = 1'b0;
        send(12, 8, 4, 1'b0, 1'b0);
        wait_drain();

        // Backpressure with stale done pulses
        out_ready = 1'b0;
        send(21, 14, 7, 1'b0, 1'b0);
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        check("bp valid seen", 64'(out_valid), 1);
        for (int j = 0; j < 5; j++) begin
            inj_done = (j == 2);
            @(negedge clk);
            check("bp out_valid", 64'(out_valid), 1);
            check("bp out_gcd", 64'(out_gcd), 7);
            check("bp in_ready", 64'(in_ready), 0);
            check("bp done_cnt", 64'(done_cnt), 64'(exp_cnt));
            @(posedge clk); #1;
        end
        inj_done  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        @(posedge clk); #1;
        check("idle stale out_valid", 64'(out_valid), 0);
        check("idle stale out_gcd", 64'(out_gcd), 7);
        check("idle stale done_cnt", 64'(done_cnt), 64'(exp_cnt));
        check("idle stale in_ready", 64'(in_ready), 1);

        // Reset in WAIT aborts without a result
        eng_hang = 1'b1;
        send(100, 75, 25, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid rst out_valid", 64'(out_valid), 0);
        check("mid rst eng_resetn", 64'(eng_resetn), 0);
        check("mid rst in_ready", 64'(in_ready), 0);
        check("mid rst done_cnt", 64'(done_cnt), 0);
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        reset    = 1'b0;
        eng_hang = 1'b0;
        @(posedge clk); #1;
        send(100, 75, 25, 1'b0, 1'b0);
        wait_drain();

        // Counter wrap: done_cnt continues 2, 3, 0, 1
        send(35, 21, 7, 1'b0, 1'b0);
        wait_drain();
        send(27, 18, 9, 1'b0, 1'b0);
        wait_drain();
        send(64, 48, 16, 1'b0, 1'b0);
        wait_drain();
        send(17, 5, 1, 1'b0, 1'b0);
        wait_drain();
        check("final done_cnt", 64'(done_cnt), 1);
        check("scoreboard empty", 64'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
